seq_code_lock: RTL and testbench
================================

// Module: seq_code_lock
// PURPOSE
//   Parametrised sequential combination lock: compares a stream of coded symbols
//   against a programmable CODE_LEN-symbol code and asserts unlock on a full match.
//   Adds failure counting with timed lockout, entry timeout, timed/forced relock and
//   in-field code reprogramming. Sits between keypad/button decode logic and the
//   actuator driver in the lock subsystem.
// PARAMETERS
//   SYM_W       2        symbol width in bits
//   CODE_LEN    4        symbols per code (>=2)
//   RESET_CODE  8'hE4    code after reset, CODE_LEN*SYM_W bits; symbol k = bits [k*SYM_W +: SYM_W]
//   UNLOCK_CYC  8        cycles unlock is held in OPEN (>=1)
//   ENTRY_TO    32       idle cycles in ENTRY before abandoning a partial entry
//   MAX_FAIL    3        consecutive failed entries before lockout (LOCKOUT_EN only)
//   LOCKOUT_CYC 16       lockout duration in cycles (LOCKOUT_EN only)
// PORTS
//   clk         in   1                   clock, rising edge
//   rst         in   1                   asynchronous reset, active-high
//   sym_valid   in   1                   sym is sampled this cycle
//   sym         in   SYM_W               entered symbol
//   code_load   in   1                   write code_in to code register (OPEN only)
//   code_in     in   CODE_LEN*SYM_W      new code
//   relock      in   1                   force OPEN -> IDLE
//   unlock      out  1                   lock open (registered)
//   fail_pulse  out  1                   one-cycle pulse per failed entry
//   locked_out  out  1                   in LOCKOUT (registered)
//   progress    out  $clog2(CODE_LEN+1)  symbols matched so far
// BEHAVIOUR
//   - Reset: state IDLE, code=RESET_CODE, progress=0, fail count=0, all counters 0;
//     unlock=0, fail_pulse=0, locked_out=0.
//   - States: IDLE, ENTRY, OPEN, LOCKOUT. All outputs registered.
//   - IDLE/ENTRY, sym_valid=1: sym == code symbol[progress] -> progress+1, state ENTRY;
//     if it was symbol CODE_LEN-1 -> OPEN, progress=0, fail count=0, unlock=1 next cycle.
//     Mismatch -> progress=0, IDLE, fail_pulse=1 next cycle, fail count+1; the
//     mismatching symbol is NOT re-evaluated as symbol 0.
//   - ENTRY: ENTRY_TO consecutive cycles without sym_valid -> IDLE, progress=0; not a failure.
//   - OPEN: unlock=1 for exactly UNLOCK_CYC cycles, then IDLE. relock=1 -> IDLE next
//     cycle. code_load=1 -> code<=code_in, IDLE next cycle. Both same cycle: code
//     written, IDLE. sym_valid ignored in OPEN.
//   - code_load outside OPEN ignored (code unchanged).
//   - Fail count saturates at MAX_FAIL; cleared only on successful entry, lockout
//     expiry or reset.
//   - Reset mid-operation: immediate return to reset values, including code register.
// CONFIGURATION
//   LOCKOUT_EN defined: mismatch that brings fail count to MAX_FAIL -> LOCKOUT (not IDLE);
//     locked_out=1 for LOCKOUT_CYC cycles; sym_valid and code_load ignored, no
//     fail_pulse in LOCKOUT; expiry -> IDLE, fail count=0, locked_out=0.
//   LOCKOUT_EN undefined: no LOCKOUT state, locked_out tied 0; failures only pulse
//     fail_pulse and return to IDLE; MAX_FAIL/LOCKOUT_CYC unused.
// TESTING
//   1. Reset, enter 0,1,2,3 (one per cycle) -> unlock=1 cycle after 4th symbol, held 8 cycles, then 0.
//   2. Enter 0,1,3 -> fail_pulse one cycle, progress=0; then 0,1,2,3 -> unlock.
//   3. LOCKOUT_EN: three entries of 3 -> 3 fail_pulses, locked_out=1 16 cycles; 0,1,2,3 during
//      lockout -> no unlock, no fail_pulse; after expiry 0,1,2,3 -> unlock.
//   4. In OPEN, code_load with code_in=8'h1B -> IDLE; 0,1,2,3 fails; 3,2,1,0 unlocks.
//   5. Enter 0,1 then 32 idle cycles -> progress=0, no fail_pulse; then 2 -> fail_pulse.
//   6. After case 4, assert rst in OPEN -> unlock=0 immediately; 0,1,2,3 unlocks again;
//      relock in OPEN -> unlock=0 next cycle.

Source files
------------

// File: rtl/seq_code_lock.sv
// Sequential combination lock: matches a symbol stream against a programmable code.
// Optional failure lockout is compiled in with `define LOCKOUT_EN.
module seq_code_lock #(
  parameter int SYM_W = 2,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*SYM_W-1:0] RESET_CODE = 8'hE4,
  parameter int UNLOCK_CYC = 8,
  parameter int ENTRY_TO = 32,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sym_valid,
  input  logic [SYM_W-1:0]              sym,
  input  logic                          code_load,
  input  logic [CODE_LEN*SYM_W-1:0]     code_in,
  input  logic                          relock,
  output logic                          unlock,
  output logic                          fail_pulse,
  output logic                          locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0] progress
);

  localparam int CODE_W = CODE_LEN * SYM_W;
  localparam int PROG_W = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int T0 = (UNLOCK_CYC > ENTRY_TO) ? UNLOCK_CYC : ENTRY_TO;
  localparam int TMAX = (T0 > LOCKOUT_CYC) ? T0 : LOCKOUT_CYC;
  localparam int TMR_W = $clog2(TMAX + 1);

`ifdef LOCKOUT_EN
  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ENTRY, OPEN} state_t;
`endif

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [PROG_W-1:0]   prog_q, prog_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                unlock_q, unlock_d;
  logic                fail_pulse_q, fail_pulse_d;
  logic [SYM_W-1:0]    exp_sym;
`ifdef LOCKOUT_EN
  logic                locked_q, locked_d;
`endif

  // Symbol the entry expects next, selected by the match progress.
  always_comb begin
    exp_sym = code_q[SYM_W-1:0];
    for (int k = 0; k < CODE_LEN; k++) begin
      if (prog_q == PROG_W'(k)) exp_sym = code_q[k*SYM_W +: SYM_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    prog_d       = prog_q;
    fail_d       = fail_q;
    tmr_d        = tmr_q;
    unlock_d     = 1'b0;
    fail_pulse_d = 1'b0;
`ifdef LOCKOUT_EN
    locked_d     = 1'b0;
`endif
    case (state_q)
      IDLE, ENTRY: begin
        if (sym_valid) begin
          tmr_d = '0;
          if (sym == exp_sym) begin
            if (prog_q == PROG_W'(CODE_LEN - 1)) begin
              state_d  = OPEN;
              prog_d   = '0;
              fail_d   = '0;
              unlock_d = 1'b1;
            end else begin
              state_d = ENTRY;
              prog_d  = prog_q + 1'b1;
            end
          end else begin
            // The failing symbol is consumed; it never restarts a new entry.
            state_d      = IDLE;
            prog_d       = '0;
            fail_pulse_d = 1'b1;
            if (fail_q != FAIL_W'(MAX_FAIL)) fail_d = fail_q + 1'b1;
`ifdef LOCKOUT_EN
            if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
              state_d  = LOCKOUT;
              locked_d = 1'b1;
            end
`endif
          end
        end else if (state_q == ENTRY) begin
          if (tmr_q == TMR_W'(ENTRY_TO - 1)) begin
            state_d = IDLE;
            prog_d  = '0;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      OPEN: begin
        unlock_d = 1'b1;
        if (code_load || relock || tmr_q == TMR_W'(UNLOCK_CYC - 1)) begin
          state_d  = IDLE;
          unlock_d = 1'b0;
          tmr_d    = '0;
          if (code_load) code_d = code_in;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`ifdef LOCKOUT_EN
      LOCKOUT: begin
        locked_d = 1'b1;
        if (tmr_q == TMR_W'(LOCKOUT_CYC - 1)) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          fail_d   = '0;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= RESET_CODE;
      prog_q       <= '0;
      fail_q       <= '0;
      tmr_q        <= '0;
      unlock_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      prog_q       <= prog_d;
      fail_q       <= fail_d;
      tmr_q        <= tmr_d;
      unlock_q     <= unlock_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

`ifdef LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end
  assign locked_out = locked_q;
`else
  assign locked_out = 1'b0;
`endif

  assign unlock     = unlock_q;
  assign fail_pulse = fail_pulse_q;
  assign progress   = prog_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Directed bench for seq_code_lock: unlock timing, failures, lockout, timeout,
// code reprogramming, asynchronous reset and relock.
module tb_seq_code_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = '0;
  logic       code_load = 1'b0;
  logic [7:0] code_in = '0;
  logic       relock = 1'b0;
  logic       unlock;
  logic       fail_pulse;
  logic       locked_out;
  logic [2:0] progress;

  int n_checks = 0;
  int n_pass = 0;

  seq_code_lock dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym(sym),
    .code_load(code_load), .code_in(code_in), .relock(relock),
    .unlock(unlock), .fail_pulse(fail_pulse), .locked_out(locked_out),
    .progress(progress)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    sym_valid = 1'b1;
    sym = s;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_checks++;
    if ({unlock, fail_pulse, locked_out, progress} !== 6'b0)
      $display("FAIL reset_outputs got %b exp 000000", {unlock, fail_pulse, locked_out, progress});
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_unlock();
    int hi;
    send(2'd0);
    n_checks++;
    if (progress !== 3'd1) $display("FAIL unlock_prog1 got %0d exp 1", progress); else n_pass++;
    send(2'd1);
    send(2'd2);
    n_checks++;
    if (progress !== 3'd3) $display("FAIL unlock_prog3 got %0d exp 3", progress); else n_pass++;
    send(2'd3);
    n_checks++;
    if (unlock !== 1'b1 || progress !== 3'd0)
      $display("FAIL unlock_open got unlock=%b prog=%0d exp unlock=1 prog=0", unlock, progress);
    else n_pass++;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (unlock === 1'b1) hi++;
      step();
    end
    n_checks++;
    if (hi != 8) $display("FAIL unlock_hold got %0d cycles exp 8", hi); else n_pass++;
    n_checks++;
    if (unlock !== 1'b0) $display("FAIL unlock_release got %b exp 0", unlock); else n_pass++;
  endtask

  task automatic test_fail();
    send(2'd0);
    send(2'd1);
    send(2'd3);
    n_checks++;
    if (fail_pulse !== 1'b1 || progress !== 3'd0 || unlock !== 1'b0)
      $display("FAIL fail_pulse got fp=%b prog=%0d unlock=%b exp fp=1 prog=0 unlock=0",
               fail_pulse, progress, unlock);
    else n_pass++;
    step();
    n_checks++;
    if (fail_pulse !== 1'b0) $display("FAIL fail_one_cycle got %b exp 0", fail_pulse); else n_pass++;
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    n_checks++;
    if (unlock !== 1'b1) $display("FAIL fail_then_unlock got %b exp 1", unlock); else n_pass++;
    idle(10);
  endtask

  task automatic test_lockout();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send(2'd3);
      if (fail_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 3) $display("FAIL lockout_pulses got %0d exp 3", pulses); else n_pass++;
`ifdef LOCKOUT_EN
    begin
      int hi;
      logic bad_unlock, bad_fp;
      hi = 0; bad_unlock = 1'b0; bad_fp = 1'b0;
      for (int i = 0; i < 24; i++) begin
        if (locked_out === 1'b1) hi++;
        if (unlock !== 1'b0) bad_unlock = 1'b1;
        if (i > 0 && fail_pulse !== 1'b0) bad_fp = 1'b1;
        if (i < 4) begin
          sym_valid = 1'b1;
          sym = 2'(i);
        end else begin
          sym_valid = 1'b0;
        end
        step();
      end
      sym_valid = 1'b0;
      n_checks++;
      if (hi != 16) $display("FAIL lockout_len got %0d cycles exp 16", hi); else n_pass++;
      n_checks++;
      if (bad_unlock || bad_fp)
        $display("FAIL lockout_ignore got unlock_seen=%b fp_seen=%b exp 0 0", bad_unlock, bad_fp);
      else n_pass++;
    end
`else
    n_checks++;
    if (locked_out !== 1'b0) $display("FAIL lockout_tied got %b exp 0", locked_out); else n_pass++;
`endif
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    n_checks++;
    if (unlock !== 1'b1 || locked_out !== 1'b0)
      $display("FAIL lockout_after got unlock=%b lo=%b exp 1 0", unlock, locked_out);
    else n_pass++;
    idle(10);
  endtask

  task automatic test_timeout();
    logic fp_seen;
    fp_seen = 1'b0;
    send(2'd0);
    send(2'd1);
    for (int i = 0; i < 31; i++) begin
      step();
      if (fail_pulse !== 1'b0) fp_seen = 1'b1;
    end
    n_checks++;
    if (progress !== 3'd2) $display("FAIL timeout_edge got prog=%0d exp 2", progress); else n_pass++;
    step();
    if (fail_pulse !== 1'b0) fp_seen = 1'b1;
    n_checks++;
    if (progress !== 3'd0 || fp_seen)
      $display("FAIL timeout_abandon got prog=%0d fp_seen=%b exp 0 0", progress, fp_seen);
    else n_pass++;
    send(2'd2);
    n_checks++;
    if (fail_pulse !== 1'b1) $display("FAIL timeout_then_fail got %b exp 1", fail_pulse); else n_pass++;
    step();
  endtask

  task automatic test_code_load();
    code_in = 8'h1B;
    code_load = 1'b1;
    step();
    code_load = 1'b0;
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    n_checks++;
    if (unlock !== 1'b1) $display("FAIL load_ignored_idle got %b exp 1", unlock); else n_pass++;
    code_load = 1'b1;
    step();
    code_load = 1'b0;
    n_checks++;
    if (unlock !== 1'b0) $display("FAIL load_to_idle got %b exp 0", unlock); else n_pass++;
    send(2'd0);
    n_checks++;
    if (fail_pulse !== 1'b1 || progress !== 3'd0)
      $display("FAIL load_old_code got fp=%b prog=%0d exp 1 0", fail_pulse, progress);
    else n_pass++;
    send(2'd3); send(2'd2); send(2'd1);
    n_checks++;
    if (progress !== 3'd3) $display("FAIL load_new_prog got %0d exp 3", progress); else n_pass++;
    send(2'd0);
    n_checks++;
    if (unlock !== 1'b1) $display("FAIL load_new_code got %b exp 1", unlock); else n_pass++;
  endtask

  task automatic test_reset_relock();
    rst = 1'b1;
    #1;
    n_checks++;
    if (unlock !== 1'b0) $display("FAIL rst_async got %b exp 0", unlock); else n_pass++;
    step();
    rst = 1'b0;
    step();
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    n_checks++;
    if (unlock !== 1'b1) $display("FAIL rst_code_restored got %b exp 1", unlock); else n_pass++;
    relock = 1'b1;
    step();
    relock = 1'b0;
    n_checks++;
    if (unlock !== 1'b0) $display("FAIL relock got %b exp 0", unlock); else n_pass++;
    send(2'd0);
    n_checks++;
    if (progress !== 3'd1) $display("FAIL relock_idle got %0d exp 1", progress); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail();
    test_lockout();
    test_timeout();
    test_code_load();
    test_reset_relock();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
